// File: rtl/piece_sprite_pkg.sv
// Shared types and defaults for the animated chess-piece sprite.
// Holds the FSM state enum and the square-to-pixel origin helper.
package piece_sprite_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DONE
  } anim_state_e;

  localparam int DEF_SPRITE_W    = 60;
  localparam int DEF_SPRITE_H    = 60;
  localparam int DEF_BOARD_X0    = 80;
  localparam int DEF_BOARD_Y0    = 0;
  localparam int DEF_MOVE_FRAMES = 16;
  localparam int DEF_ROM_LAT     = 1;
  localparam int DEF_INIT_COL    = 0;
  localparam int DEF_INIT_ROW    = 0;

  localparam logic [3:0] DEF_TRANSP_IDX = 4'hF;

  function automatic logic [10:0] sq_origin(
    input logic [2:0] idx,
    input int         base,
    input int         size
  );
    return 11'(base + int'(idx) * size);
  endfunction

endpackage

// File: rtl/sprite_pipe_delay.sv
// Reset-clearable shift register used to line up hit/blank
// with the external sprite ROM read data.
module sprite_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/piece_sprite_anim.sv
// Chess piece sprite: slides between squares one step per frame
// and renders through an external palette-index ROM.
module piece_sprite_anim
  import piece_sprite_pkg::*;
#(
  parameter int         SPRITE_W    = DEF_SPRITE_W,
  parameter int         SPRITE_H    = DEF_SPRITE_H,
  parameter int         BOARD_X0    = DEF_BOARD_X0,
  parameter int         BOARD_Y0    = DEF_BOARD_Y0,
  parameter int         MOVE_FRAMES = DEF_MOVE_FRAMES,
  parameter int         ROM_LAT     = DEF_ROM_LAT,
  parameter logic [3:0] TRANSP_IDX  = DEF_TRANSP_IDX,
  parameter int         INIT_COL    = DEF_INIT_COL,
  parameter int         INIT_ROW    = DEF_INIT_ROW,
  localparam int        ADDR_W      = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              move_start,
  input  logic [2:0]        from_col,
  input  logic [2:0]        from_row,
  input  logic [2:0]        to_col,
  input  logic [2:0]        to_row,
  input  logic              captured,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic              pix_on,
  output logic [3:0]        pix_idx,
  output logic              busy,
  output logic              done
);

  localparam int SHIFT = $clog2(MOVE_FRAMES);
  localparam int CNT_W = SHIFT + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_FRAMES);

  localparam logic [10:0] INIT_X =
    sq_origin(3'(INIT_COL), BOARD_X0, SPRITE_W);
  localparam logic [10:0] INIT_Y =
    sq_origin(3'(INIT_ROW), BOARD_Y0, SPRITE_H);

  anim_state_e      state_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [10:0]      from_x_q, from_y_q;
  logic [10:0]      to_x_q, to_y_q;
  logic [10:0]      pos_x_q, pos_y_q;
  logic             busy_q, done_q;

  logic [CNT_W-1:0] cnt_d;
  logic [10:0]      fx_d, fy_d, tx_d, ty_d;
  logic [10:0]      step_x_d, step_y_d;

  // Product is widened: a 7-square move times 64 frames overflows 12 bits.
  function automatic logic [10:0] lerp(
    input logic [10:0]      a,
    input logic [10:0]      b,
    input logic [CNT_W-1:0] k
  );
    logic signed [11:0] delta;
    logic signed [19:0] dw;
    logic signed [19:0] kw;
    logic signed [19:0] prod;
    logic signed [19:0] sum;
    delta = $signed({1'b0, b}) - $signed({1'b0, a});
    dw    = delta;
    kw    = $signed(20'(k));
    prod  = (dw * kw) >>> SHIFT;
    sum   = $signed({9'b0, a}) + prod;
    return 11'(sum);
  endfunction

  always_comb begin
    cnt_d    = frame_cnt_q + CNT_W'(1);
    fx_d     = sq_origin(from_col, BOARD_X0, SPRITE_W);
    fy_d     = sq_origin(from_row, BOARD_Y0, SPRITE_H);
    tx_d     = sq_origin(to_col, BOARD_X0, SPRITE_W);
    ty_d     = sq_origin(to_row, BOARD_Y0, SPRITE_H);
    step_x_d = lerp(from_x_q, to_x_q, cnt_d);
    step_y_d = lerp(from_y_q, to_y_q, cnt_d);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= '0;
      from_x_q    <= INIT_X;
      from_y_q    <= INIT_Y;
      to_x_q      <= INIT_X;
      to_y_q      <= INIT_Y;
      pos_x_q     <= INIT_X;
      pos_y_q     <= INIT_Y;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (move_start) begin
            from_x_q    <= fx_d;
            from_y_q    <= fy_d;
            to_x_q      <= tx_d;
            to_y_q      <= ty_d;
            pos_x_q     <= fx_d;
            pos_y_q     <= fy_d;
            frame_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_MOVING;
          end
        end
        S_MOVING: begin
          if (frame_start) begin
            frame_cnt_q <= cnt_d;
            if (cnt_d == LAST_CNT) begin
              pos_x_q <= to_x_q;
              pos_y_q <= to_y_q;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pos_x_q <= step_x_d;
              pos_y_q <= step_y_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  logic [10:0]       px_d, py_d;
  logic [10:0]       ofs_x_d, ofs_y_d;
  logic              hit_d;
  logic [ADDR_W-1:0] addr_d;

  // 11-bit unsigned compares: right/bottom edges never wrap.
  always_comb begin
    px_d    = {1'b0, DrawX};
    py_d    = {1'b0, DrawY};
    ofs_x_d = px_d - pos_x_q;
    ofs_y_d = py_d - pos_y_q;
    hit_d   = (px_d >= pos_x_q)
            && (px_d < pos_x_q + 11'(SPRITE_W))
            && (py_d >= pos_y_q)
            && (py_d < pos_y_q + 11'(SPRITE_H));
    addr_d  = '0;
    if (hit_d) begin
      addr_d = ADDR_W'(ofs_x_d)
             + ADDR_W'(ofs_y_d) * ADDR_W'(SPRITE_W);
    end
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              hit_q, blank_q;
  logic              hit_al, blank_al;
  logic              pix_on_q;
  logic [3:0]        pix_idx_q;
  logic              opaque;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      rom_addr_q <= addr_d;
      hit_q      <= hit_d;
      blank_q    <= blank;
    end
  end

  sprite_pipe_delay #(
    .DEPTH (ROM_LAT),
    .WIDTH (2)
  ) u_align (
    .clk (vga_clk),
    .rst (reset),
    .d_i ({hit_q, blank_q}),
    .q_o ({hit_al, blank_al})
  );

  assign opaque = hit_al & blank_al & ~captured
                & (rom_q != TRANSP_IDX);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pix_on_q  <= 1'b0;
      pix_idx_q <= 4'h0;
    end else begin
      pix_on_q  <= opaque;
      pix_idx_q <= opaque ? rom_q : 4'h0;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pix_on   = pix_on_q;
  assign pix_idx  = pix_idx_q;

endmodule

// File: tb/tb_piece_sprite_anim.sv
// Directed bench for piece_sprite_anim: pixel pipeline, moves,
// done pulse and reset abort, checked with immediate assertions.
module tb_piece_sprite_anim;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, move_start, captured;
  logic [2:0]  from_col, from_row, to_col, to_row;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q;
  logic        pix_on;
  logic [3:0]  pix_idx;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 vga_clk = ~vga_clk;

  piece_sprite_anim dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .move_start  (move_start),
    .from_col    (from_col),
    .from_row    (from_row),
    .to_col      (to_col),
    .to_row      (to_row),
    .captured    (captured),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_on      (pix_on),
    .pix_idx     (pix_idx),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(
    input string tag,
    input int    ex,
    input int    ey
  );
    check({tag, "_x"}, 32'(dut.pos_x_q), ex);
    check({tag, "_y"}, 32'(dut.pos_y_q), ey);
  endtask

  task automatic pixel(
    input string      tag,
    input logic [9:0] x,
    input logic [9:0] y,
    input logic       b,
    input logic [3:0] q,
    input logic       cap,
    input int         e_addr,
    input int         e_on,
    input int         e_idx
  );
    @(negedge vga_clk);
    DrawX = x; DrawY = y; blank = b;
    rom_q = q; captured = cap;
    @(negedge vga_clk);
    check({tag, "_addr"}, 32'(rom_addr), e_addr);
    DrawX = 10'd1000; DrawY = 10'd1000;
    @(negedge vga_clk);
    @(negedge vga_clk);
    check({tag, "_on"}, 32'(pix_on), e_on);
    check({tag, "_idx"}, 32'(pix_idx), e_idx);
    rom_q = 4'h0; captured = 1'b0; blank = 1'b1;
  endtask

  task automatic frame();
    @(negedge vga_clk);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic move(
    input logic [2:0] fc, input logic [2:0] fr,
    input logic [2:0] tc, input logic [2:0] tr
  );
    @(negedge vga_clk);
    from_col = fc; from_row = fr;
    to_col = tc; to_row = tr;
    move_start = 1'b1;
    @(negedge vga_clk);
    move_start = 1'b0;
  endtask

  initial begin
    int px, py;
    reset = 1'b1;
    DrawX = 10'd1000; DrawY = 10'd1000;
    blank = 1'b1; frame_start = 1'b0;
    move_start = 1'b0; captured = 1'b0;
    from_col = '0; from_row = '0;
    to_col = '0; to_row = '0;
    rom_q = 4'h0;
    repeat (3) @(negedge vga_clk);
    reset = 1'b0;

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_pix_on", 32'(pix_on), 0);
    check("rst_pix_idx", 32'(pix_idx), 0);
    check_pos("rst_pos", 80, 0);

    pixel("tl", 10'd80, 10'd0, 1'b1, 4'd3, 1'b0, 0, 1, 3);
    pixel("br", 10'd139, 10'd59, 1'b1, 4'd5, 1'b0, 3599, 1, 5);
    pixel("x_excl", 10'd140, 10'd0, 1'b1, 4'd5, 1'b0, 0, 0, 0);
    pixel("y_excl", 10'd80, 10'd60, 1'b1, 4'd5, 1'b0, 0, 0, 0);
    pixel("x_left", 10'd79, 10'd0, 1'b1, 4'd5, 1'b0, 0, 0, 0);
    pixel("mid", 10'd100, 10'd10, 1'b1, 4'd9, 1'b0, 620, 1, 9);
    pixel("transp", 10'd100, 10'd10, 1'b1, 4'hF, 1'b0, 620, 0, 0);
    pixel("blank0", 10'd100, 10'd10, 1'b0, 4'd3, 1'b0, 620, 0, 0);
    pixel("capt", 10'd100, 10'd10, 1'b1, 4'd3, 1'b1, 620, 0, 0);

    // Straight move (0,0)->(2,0)
    move(3'd0, 3'd0, 3'd2, 3'd0);
    check("m1_busy", 32'(busy), 1);
    check_pos("m1_start", 80, 0);
    repeat (3) @(negedge vga_clk);
    check_pos("m1_hold", 80, 0);
    repeat (8) frame();
    check_pos("m1_f8", 140, 0);
    move(3'd7, 3'd7, 3'd0, 3'd0);
    check_pos("m1_ignore", 140, 0);
    check("m1_ign_busy", 32'(busy), 1);
    frame();
    check_pos("m1_f9", 147, 0);
    repeat (6) frame();
    check_pos("m1_f15", 192, 0);
    check("m1_f15_busy", 32'(busy), 1);
    check("m1_f15_done", 32'(done), 0);
    frame();
    check_pos("m1_f16", 200, 0);
    check("m1_done", 32'(done), 1);
    check("m1_done_busy", 32'(busy), 0);
    from_col = 3'd5; from_row = 3'd5;
    to_col = 3'd6; to_row = 3'd6;
    move_start = 1'b1;
    @(negedge vga_clk);
    move_start = 1'b0;
    check("m1_done_len", 32'(done), 0);
    check("m1_post_busy", 32'(busy), 0);
    check_pos("m1_post", 200, 0);
    pixel("m1_hit", 10'd200, 10'd0, 1'b1, 4'd7, 1'b0, 0, 1, 7);
    pixel("m1_miss", 10'd199, 10'd0, 1'b1, 4'd7, 1'b0, 0, 0, 0);

    // Diagonal move (7,7)->(0,0): negative deltas
    move(3'd7, 3'd7, 3'd0, 3'd0);
    check_pos("m2_start", 500, 420);
    px = 500; py = 420;
    for (int k = 1; k <= 16; k++) begin
      frame();
      check("m2_mono_x", 32'(dut.pos_x_q < 11'(px)), 1);
      check("m2_mono_y", 32'(dut.pos_y_q < 11'(py)), 1);
      px = int'(dut.pos_x_q);
      py = int'(dut.pos_y_q);
      if (k == 1) check_pos("m2_f1", 473, 393);
      if (k == 8) check_pos("m2_f8", 290, 210);
      if (k == 15) check_pos("m2_f15", 106, 26);
    end
    check_pos("m2_end", 80, 0);
    check("m2_done", 32'(done), 1);
    @(negedge vga_clk);
    check("m2_busy", 32'(busy), 0);

    // Null move (3,3)->(3,3)
    move(3'd3, 3'd3, 3'd3, 3'd3);
    for (int k = 1; k <= 15; k++) begin
      frame();
      check_pos("m3_const", 260, 180);
      check("m3_busy", 32'(busy), 1);
    end
    frame();
    check("m3_done", 32'(done), 1);
    check_pos("m3_end", 260, 180);
    @(negedge vga_clk);

    // Reset mid-move with coincident frame_start/move_start
    move(3'd0, 3'd0, 3'd4, 3'd0);
    repeat (5) frame();
    check_pos("m4_f5", 155, 0);
    @(negedge vga_clk);
    reset = 1'b1; frame_start = 1'b1; move_start = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0; frame_start = 1'b0; move_start = 1'b0;
    check_pos("m4_rst", 80, 0);
    check("m4_rst_busy", 32'(busy), 0);
    check("m4_rst_done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      check("m4_no_done", 32'(done), 0);
      check("m4_idle", 32'(busy), 0);
    end
    repeat (3) frame();
    check_pos("m4_stay", 80, 0);
    pixel("m4_hit", 10'd80, 10'd0, 1'b1, 4'd2, 1'b0, 0, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
